// File: rtl/axis_coeff_loader_pkg.sv
// axis_coeff_loader_pkg: shared sizes, keep-nibble helpers and FSM encoding for the coefficient loader
package axis_coeff_loader_pkg;
    localparam int PRM_ADDR       = 12;
    localparam int PRM_COEFFS     = 1 << PRM_ADDR;
    localparam int PRM_DATA_WIDTH = 32;
    localparam int BEAT_W         = 2 * PRM_DATA_WIDTH;
    localparam int KEEP_W         = BEAT_W / 8;
    localparam int NIB_W          = KEEP_W / 2;
    localparam logic [PRM_ADDR:0] MAX_COUNT = (PRM_ADDR + 1)'(PRM_COEFFS);
    localparam logic [NIB_W-1:0]  KEEP_FULL = '1;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DRAIN, ST_DONE} state_t;

    function automatic logic word_ok(input logic [NIB_W-1:0] nib);
        return nib == KEEP_FULL;
    endfunction
endpackage

// File: rtl/axis_beat_hold.sv
// axis_beat_hold: one-beat hold register that hands out the lo word then the hi word of a stream beat
module axis_beat_hold
    import axis_coeff_loader_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              act_i,
    input  logic              flush_i,
    input  logic              pop_i,
    input  logic              tvalid_i,
    input  logic [BEAT_W-1:0] tdata_i,
    input  logic [KEEP_W-1:0] tkeep_i,
    input  logic              tlast_i,
    output logic              tready_o,
    output logic [BEAT_W-1:0] data_o,
    output logic              lo_o,
    output logic              hi_o,
    output logic              last_o,
    output logic              final_o
);
    logic [BEAT_W-1:0] data_q;
    logic              lo_q, hi_q, last_q;

    assign final_o  = pop_i && !(lo_q && hi_q);
    assign tready_o = act_i && (!(lo_q || hi_q) || final_o);
    assign data_o   = data_q;
    assign lo_o     = lo_q;
    assign hi_o     = hi_q;
    assign last_o   = last_q;

    // Flush wins over a same-cycle handshake: a beat taken while leaving LOAD is discarded.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q <= '0;
            lo_q   <= 1'b0;
            hi_q   <= 1'b0;
            last_q <= 1'b0;
        end else if (flush_i) begin
            lo_q   <= 1'b0;
            hi_q   <= 1'b0;
            last_q <= 1'b0;
        end else if (tvalid_i && tready_o) begin
            data_q <= tdata_i;
            lo_q   <= word_ok(tkeep_i[NIB_W-1:0]);
            hi_q   <= word_ok(tkeep_i[KEEP_W-1:NIB_W]);
            last_q <= tlast_i;
        end else if (pop_i) begin
            lo_q <= 1'b0;
            hi_q <= hi_q && lo_q;
        end
    end
endmodule

// File: rtl/axis_coeff_loader.sv
// axis_coeff_loader: turns 64-bit DMA stream beats into 32-bit polynomial RAM writes for one programmed load
module axis_coeff_loader
    import axis_coeff_loader_pkg::*;
(
    input  logic                      iSYS_CLK,
    input  logic                      iSYS_RST,
    input  logic                      iSTART,
    input  logic [PRM_ADDR:0]         iCOEF_NUM,
    input  logic [PRM_ADDR-1:0]       iBASE_ADDR,
    output logic                      oBUSY,
    output logic                      oDONE,
    output logic                      oERR_SHORT,
    output logic                      oERR_LONG,
    input  logic                      iS_AXIS_TVALID,
    output logic                      oS_AXIS_TREADY,
    input  logic [BEAT_W-1:0]         iS_AXIS_TDATA,
    input  logic [KEEP_W-1:0]         iS_AXIS_TKEEP,
    input  logic                      iS_AXIS_TLAST,
    output logic                      oRAM_WE,
    output logic [PRM_ADDR-1:0]       oRAM_ADDR,
    output logic [PRM_DATA_WIDTH-1:0] oRAM_DATA
);
    state_t                state_q, state_d;
    logic [PRM_ADDR:0]     count_q, idx_q, count_d;
    logic [PRM_ADDR-1:0]   base_q;
    logic                  busy_q, done_q, err_short_q, err_long_q;
    logic                  set_short, set_long;
    logic [BEAT_W-1:0]     h_data;
    logic                  h_lo, h_hi, h_last, h_final, tready, hs, wr, last_idx, empty_last;

    axis_beat_hold u_hold (
        .clk_i    (iSYS_CLK),
        .rst_i    (iSYS_RST),
        .act_i    (state_q == ST_LOAD || state_q == ST_DRAIN),
        .flush_i  (state_d != ST_LOAD),
        .pop_i    (wr),
        .tvalid_i (iS_AXIS_TVALID),
        .tdata_i  (iS_AXIS_TDATA),
        .tkeep_i  (iS_AXIS_TKEEP),
        .tlast_i  (iS_AXIS_TLAST),
        .tready_o (tready),
        .data_o   (h_data),
        .lo_o     (h_lo),
        .hi_o     (h_hi),
        .last_o   (h_last),
        .final_o  (h_final)
    );

    assign hs         = iS_AXIS_TVALID && tready;
    assign wr         = state_q == ST_LOAD && (h_lo || h_hi);
    assign last_idx   = wr && (idx_q + (PRM_ADDR + 1)'(1) == count_q);
    assign empty_last = hs && iS_AXIS_TLAST && !word_ok(iS_AXIS_TKEEP[NIB_W-1:0])
                        && !word_ok(iS_AXIS_TKEEP[KEEP_W-1:NIB_W]);
    assign count_d    = (iCOEF_NUM == '0 || iCOEF_NUM > MAX_COUNT) ? MAX_COUNT : iCOEF_NUM;

    assign oBUSY          = busy_q;
    assign oDONE          = done_q;
    assign oERR_SHORT     = err_short_q;
    assign oERR_LONG      = err_long_q;
    assign oS_AXIS_TREADY = tready;
    assign oRAM_WE        = wr;
    assign oRAM_ADDR      = base_q + idx_q[PRM_ADDR-1:0];
    assign oRAM_DATA      = h_lo ? h_data[PRM_DATA_WIDTH-1:0] : h_data[BEAT_W-1:PRM_DATA_WIDTH];

    // A trailing empty TLAST beat taken with the final write means the packet ended exactly on count.
    always_comb begin
        state_d   = state_q;
        set_short = 1'b0;
        set_long  = 1'b0;
        if (state_q == ST_IDLE) begin
            state_d = iSTART ? ST_LOAD : ST_IDLE;
        end else if (state_q == ST_DONE) begin
            state_d = ST_IDLE;
        end else if (state_q == ST_DRAIN) begin
            state_d = (hs && iS_AXIS_TLAST) ? ST_DONE : ST_DRAIN;
        end else if (last_idx) begin
            if (h_final && (h_last || empty_last)) begin
                state_d = ST_DONE;
            end else begin
                set_long = 1'b1;
                state_d  = (h_last || (hs && iS_AXIS_TLAST)) ? ST_DONE : ST_DRAIN;
            end
        end else if (h_last && (h_final || !(h_lo || h_hi))) begin
            set_short = 1'b1;
            state_d   = ST_DONE;
        end
    end

    always_ff @(posedge iSYS_CLK) begin
        if (iSYS_RST) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            idx_q       <= '0;
            base_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= state_d != ST_IDLE;
            done_q  <= state_d == ST_DONE;
            if (state_q == ST_IDLE && iSTART) begin
                count_q     <= count_d;
                base_q      <= iBASE_ADDR;
                idx_q       <= '0;
                err_short_q <= 1'b0;
                err_long_q  <= 1'b0;
            end
            if (wr) idx_q <= idx_q + (PRM_ADDR + 1)'(1);
            if (set_short) err_short_q <= 1'b1;
            if (set_long) err_long_q <= 1'b1;
        end
    end
endmodule

// File: doc/axis_coeff_loader.md
Name: axis_coeff_loader

Overview:
Ingress stage of the accelerator body. Sits directly behind the 64-bit DMA AXI-Stream slave port and converts each stream beat into one or two 32-bit coefficient writes to the polynomial RAM. It runs a single polynomial load of a programmed length and reports clean completion, short-stream and long-stream errors to the control logic.

Parameters:
PRM_ADDR, 12, polynomial RAM address width
PRM_COEFFS, 4096, maximum coefficients per load (2^PRM_ADDR)
PRM_DATA_WIDTH, 32, coefficient width; the stream beat is 2*PRM_DATA_WIDTH

Ports:
iSYS_CLK  in  1  system clock
iSYS_RST  in  1  synchronous, active-high reset
iSTART  in  1  one-cycle pulse that starts a load; sampled only in IDLE
iCOEF_NUM  in  PRM_ADDR+1  coefficient count, 1..PRM_COEFFS; sampled on iSTART
iBASE_ADDR  in  PRM_ADDR  first RAM address; sampled on iSTART
oBUSY  out  1  high from the cycle after iSTART until DONE is left
oDONE  out  1  one-cycle completion pulse
oERR_SHORT  out  1  sticky; tlast arrived before iCOEF_NUM words were written
oERR_LONG  out  1  sticky; data remained after iCOEF_NUM words were written
iS_AXIS_TVALID  in  1  stream valid
oS_AXIS_TREADY  out  1  stream ready
iS_AXIS_TDATA  in  64  [31:0] = first coefficient, [63:32] = second coefficient
iS_AXIS_TKEEP  in  8  nibble-granular word valid
iS_AXIS_TLAST  in  1  end of packet
oRAM_WE  out  1  RAM write enable
oRAM_ADDR  out  PRM_ADDR  RAM write address
oRAM_DATA  out  PRM_DATA_WIDTH  RAM write data

Behaviour:
- One clock, iSYS_CLK. Reset is synchronous and active-high on iSYS_RST.
- Reset values: state IDLE; oBUSY=0, oDONE=0, both error flags 0, oS_AXIS_TREADY=0, oRAM_WE=0, oRAM_ADDR=0, oRAM_DATA=0; hold register empty.
- Reset mid-load: the load aborts immediately. No oDONE pulse. The partial RAM contents are left as they are.
- Hold register: 64-bit data, lo_vld, hi_vld, last.
  - lo_vld = (TKEEP[3:0]==4'hF). hi_vld = (TKEEP[7:4]==4'hF).
  - Any other nibble value marks that word invalid. A beat with TKEEP=0 carries only TLAST.
- oS_AXIS_TREADY = (state is LOAD or DRAIN) and (hold empty, or hold's final valid word is written this cycle).
  - This gives a sustained rate of 1 coefficient per cycle.
- Write order: the lo word first, then the hi word. Each write occupies one cycle. Invalid words are skipped and consume no cycle.
- Latency: the first oRAM_WE is asserted the cycle after the beat handshake.
- oRAM_ADDR = (base + idx) mod 2^PRM_ADDR. The address wraps silently with no error.
- States:
  - IDLE: iSTART -> LOAD. Latch count and base; idx=0; clear both error flags.
  - LOAD: write the hold words.
    - After the write with idx+1==count:
      - If this word is the hold's last valid word and last=1 -> DONE.
      - Otherwise -> set oERR_LONG, discard the remaining hold word, and go to DRAIN.
        - If the discarded hold had last=1, go to DONE instead of DRAIN.
    - A hold with last=1 emptied while idx<count -> set oERR_SHORT -> DONE.
  - DRAIN: accept beats with ready held high and no writes. On a handshake with TLAST=1 -> DONE.
  - DONE: oDONE=1 for one cycle, oBUSY drops -> IDLE.
- iSTART in any state other than IDLE is ignored.
- iCOEF_NUM=0 or >PRM_COEFFS is treated as PRM_COEFFS.
- Simultaneous events:
  - A handshake in the same cycle as the final write loads the hold.
  - A beat with TLAST=1 and TKEEP=0 arriving exactly when idx==count is a clean finish.

Decomposition:
- Shared package: state encoding (IDLE/LOAD/DRAIN/DONE), PRM_COEFFS, PRM_ADDR, PRM_DATA_WIDTH, keep-nibble constants.
- One sub-module is natural: axis_beat_hold. It holds the 64-bit skid/hold register with lo/hi/last flags and the ready generation. The FSM and address counter stay in the top module.

Test Plan:
- Count=4, base=0x000, 2 beats of TKEEP=FF with TLAST on the 2nd, continuous TVALID -> writes 0..3 on 4 consecutive cycles; oDONE is high the cycle after the last write; no errors.
- Count=3, base=0xFFE, beats FF then 0F with TLAST -> writes go to addresses 0xFFE, 0xFFF, 0x000; oDONE; no errors.
- Count=8, tlast on beat 2 (4 words) -> 4 writes; oERR_SHORT=1; oDONE pulse.
- Count=2, 3 beats of FF with TLAST on the 3rd -> 2 writes; oERR_LONG=1; the remaining 2 beats are accepted without writes; oDONE after the TLAST handshake.
- Random TVALID gaps of 0-3 cycles, count=4096 -> 4096 writes with correct data order; TREADY never drops while the hold is drainable.
- iSYS_RST asserted for one cycle mid-load -> the next cycle has all outputs at reset values and no oDONE; a subsequent iSTART runs normally.
